// File: rtl/microstep_sequencer.sv
// Microcode step sequencer: instruction register plus microstep counter forming the
// microcode ROM address, with an instruction-boundary halt/resume controller and overrun fault.
module microstep_sequencer #(
  parameter int STEP_WIDTH = 4,
  parameter int IR_WIDTH   = 8,
  parameter int MAX_STEP   = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           step_clr,
  input  logic                           ir_load,
  input  logic [IR_WIDTH-1:0]            ir_in,
  input  logic                           halt_req,
  input  logic                           resume,
  output logic [STEP_WIDTH-1:0]          step,
  output logic [IR_WIDTH-1:0]            ir,
  output logic [IR_WIDTH+STEP_WIDTH-1:0] rom_addr,
  output logic                           fetch,
  output logic                           running,
  output logic                           halted,
  output logic                           overrun,
  output logic                           fault
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } state_t;

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(MAX_STEP);

  state_t state;
  logic   wrap;
  logic   boundary;

  // Terminate request beats the wrap: a cleared step never counts as an overrun.
  function automatic logic [STEP_WIDTH-1:0] next_step(
    input logic [STEP_WIDTH-1:0] cur,
    input logic                  clr
  );
    if (clr || (cur == LAST_STEP))
      next_step = '0;
    else
      next_step = cur + STEP_WIDTH'(1);
  endfunction

  assign wrap     = (step == LAST_STEP);
  assign boundary = step_clr || wrap;
  assign rom_addr = {ir, step};
  assign fetch    = (step == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      step    <= '0;
      ir      <= '0;
      running <= 1'b1;
      halted  <= 1'b0;
      overrun <= 1'b0;
      fault   <= 1'b0;
    end else if (!en) begin
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state != HALTED) begin
        step <= next_step(step, step_clr);
        if (ir_load)
          ir <= ir_in;
        if (wrap && !step_clr) begin
          overrun <= 1'b1;
          fault   <= 1'b1;
        end
      end
      // Halt only ever lands on an instruction boundary, where step is already heading to 0.
      case (state)
        RUN: begin
          if (halt_req) begin
            running <= 1'b0;
            if (boundary) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state  <= HALT_PEND;
            end
          end
        end
        HALT_PEND: begin
          if (boundary) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state   <= RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          running <= 1'b1;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microstep_sequencer.sv
// Bench for microstep_sequencer: directed vector table followed by randomized cycles
// compared against a behavioural model of the sequencer.
module tb_microstep_sequencer;

  localparam int SW = 4;
  localparam int IW = 8;
  localparam int MS = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          step_clr = 1'b0;
  logic          ir_load = 1'b0;
  logic [IW-1:0] ir_in = '0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic [SW-1:0] step;
  logic [IW-1:0] ir;
  logic [IW+SW-1:0] rom_addr;
  logic          fetch;
  logic          running;
  logic          halted;
  logic          overrun;
  logic          fault;

  int total = 0;
  int bad = 0;

  microstep_sequencer #(.STEP_WIDTH(SW), .IR_WIDTH(IW), .MAX_STEP(MS)) dut (
    .clk(clk), .rst(rst), .en(en), .step_clr(step_clr), .ir_load(ir_load),
    .ir_in(ir_in), .halt_req(halt_req), .resume(resume), .step(step), .ir(ir),
    .rom_addr(rom_addr), .fetch(fetch), .running(running), .halted(halted),
    .overrun(overrun), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, clr, ld;
    logic [7:0] irin;
    logic       hreq, res;
    int         e_step, e_ir;
    logic       e_run, e_halt, e_ov, e_f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic c, input logic l,
                     input logic [7:0] ii, input logic h, input logic rs,
                     input int es, input int ei, input logic erun, input logic ehalt,
                     input logic eov, input logic ef);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.ld = l; v.irin = ii; v.hreq = h; v.res = rs;
    v.e_step = es; v.e_ir = ei; v.e_run = erun; v.e_halt = ehalt; v.e_ov = eov; v.e_f = ef;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic e, input logic c, input logic l,
                             input logic [7:0] ii, input logic h, input logic rs);
    rst = r; en = e; step_clr = c; ir_load = l; ir_in = ii; halt_req = h; resume = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int es, input int ei, input logic erun,
                           input logic ehalt, input logic eov, input logic ef);
    logic [IW+SW-1:0] ea;
    ea = {IW'(ei), SW'(es)};
    chk({tag, ".step"}, 32'(step), 32'(es));
    chk({tag, ".ir"}, 32'(ir), 32'(ei));
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(ea));
    chk({tag, ".fetch"}, 32'(fetch), 32'(es == 0));
    chk({tag, ".flags(run,halt,ov,fault)"}, 32'({running, halted, overrun, fault}),
        32'({erun, ehalt, eov, ef}));
  endtask

  // Behavioural model: 0 = running, 1 = halt pending, 2 = halted.
  int m_step, m_ir, m_mode;
  bit m_ov, m_fault;

  task automatic model_edge(input logic r, input logic e, input logic c, input logic l,
                            input logic [7:0] ii, input logic h, input logic rs);
    bit at_end;
    if (r) begin
      m_step = 0; m_ir = 0; m_mode = 0; m_ov = 0; m_fault = 0;
      return;
    end
    if (!e) begin
      m_ov = 0;
      return;
    end
    at_end = c || (m_step == MS);
    m_ov = 0;
    if (m_mode != 2) begin
      if (!c && m_step == MS) begin
        m_ov = 1;
        m_fault = 1;
      end
      m_step = at_end ? 0 : (m_step + 1) % (1 << SW);
      if (l) m_ir = ii;
    end
    if (m_mode == 0 && h) m_mode = at_end ? 2 : 1;
    else if (m_mode == 1 && at_end) m_mode = 2;
    else if (m_mode == 2 && rs) m_mode = 0;
  endtask

  initial begin
    // Reset, then free run through the wrap.
    add(1,0,0,0,8'h00,0,0, 0,8'h00,1,0,0,0);
    for (int i = 1; i <= 15; i++) add(0,1,0,0,8'h00,0,0, i,8'h00,1,0,0,0);
    add(0,1,0,0,8'h00,0,0, 0,8'h00,1,0,1,1);
    add(0,1,0,0,8'h00,0,0, 1,8'h00,1,0,0,1);
    // Early terminate at step 5.
    add(1,1,0,0,8'h00,0,0, 0,8'h00,1,0,0,0);
    for (int i = 1; i <= 5; i++) add(0,1,0,0,8'h00,0,0, i,8'h00,1,0,0,0);
    add(0,1,1,0,8'h00,0,0, 0,8'h00,1,0,0,0);
    // IR load alongside a terminate so the address starts at A70.
    add(0,1,1,1,8'hA7,0,0, 0,8'hA7,1,0,0,0);
    for (int i = 1; i <= 3; i++) add(0,1,0,0,8'h00,0,0, i,8'hA7,1,0,0,0);
    // Halt requested at step 2, taken at the step_clr at step 4.
    add(0,1,1,0,8'h00,0,0, 0,8'hA7,1,0,0,0);
    add(0,1,0,0,8'h00,0,0, 1,8'hA7,1,0,0,0);
    add(0,1,0,0,8'h00,0,0, 2,8'hA7,1,0,0,0);
    add(0,1,0,0,8'h00,1,0, 3,8'hA7,0,0,0,0);
    add(0,1,0,0,8'h00,0,0, 4,8'hA7,0,0,0,0);
    add(0,1,1,0,8'h00,0,0, 0,8'hA7,0,1,0,0);
    for (int i = 0; i < 10; i++) add(0,1,1,1,8'h55,1,0, 0,8'hA7,0,1,0,0);
    add(0,1,0,0,8'h00,0,1, 0,8'hA7,1,0,0,0);
    add(0,1,0,0,8'h00,0,0, 1,8'hA7,1,0,0,0);
    // Simultaneous halt_req, step_clr and ir_load at step 7.
    for (int i = 2; i <= 7; i++) add(0,1,0,0,8'h00,0,0, i,8'hA7,1,0,0,0);
    add(0,1,1,1,8'h3C,1,0, 0,8'h3C,0,1,0,0);
    add(0,1,0,0,8'h00,0,1, 0,8'h3C,1,0,0,0);
    // Wrap to set fault, then enable freeze at step 9.
    for (int i = 1; i <= 15; i++) add(0,1,0,0,8'h00,0,0, i,8'h3C,1,0,0,0);
    add(0,1,0,0,8'h00,0,0, 0,8'h3C,1,0,1,1);
    for (int i = 1; i <= 9; i++) add(0,1,0,0,8'h00,0,0, i,8'h3C,1,0,0,1);
    for (int i = 0; i < 4; i++) add(0,0,1,1,8'h11,1,0, 9,8'h3C,1,0,0,1);
    // Halt request landing exactly on a wrap boundary.
    for (int i = 10; i <= 15; i++) add(0,1,0,0,8'h00,0,0, i,8'h3C,1,0,0,1);
    add(0,1,0,0,8'h00,1,0, 0,8'h3C,0,1,1,1);
    add(0,0,0,0,8'h00,0,1, 0,8'h3C,0,1,0,1);
    // Reset with enable low, while halted.
    add(1,0,0,0,8'h00,0,0, 0,8'h00,1,0,0,0);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      drive_cycle(v.rst, v.en, v.clr, v.ld, v.irin, v.hreq, v.res);
      check_all($sformatf("vec%0d", k), v.e_step, v.e_ir, v.e_run, v.e_halt, v.e_ov, v.e_f);
    end

    // Hand sequence: halt pending, then the wrap is the boundary that halts.
    drive_cycle(1,1,0,0,8'h00,0,0);
    drive_cycle(0,1,0,0,8'h00,1,0);
    for (int i = 0; i < 13; i++) drive_cycle(0,1,0,0,8'h00,0,0);
    check_all("pend_at14", 14, 0, 0, 0, 0, 0);
    drive_cycle(0,1,0,0,8'h00,0,0);
    check_all("pend_at15", 15, 0, 0, 0, 0, 0);
    drive_cycle(0,1,0,0,8'h00,0,0);
    check_all("pend_wrap_halt", 0, 0, 0, 1, 1, 1);
    drive_cycle(0,1,0,0,8'h00,0,0);
    check_all("halted_hold", 0, 0, 0, 1, 0, 1);

    // Randomized phase against the model.
    m_step = 0; m_ir = 0; m_mode = 0; m_ov = 0; m_fault = 0;
    drive_cycle(1,1,0,0,8'h00,0,0);
    check_all("rand_reset", m_step, m_ir, 1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, e, c, l, h, rs;
      logic [7:0] ii;
      r  = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 85);
      c  = ($urandom_range(0, 7) == 0);
      l  = ($urandom_range(0, 3) == 0);
      ii = 8'($urandom);
      h  = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 5) == 0);
      model_edge(r, e, c, l, ii, h, rs);
      drive_cycle(r, e, c, l, ii, h, rs);
      check_all($sformatf("rand%0d", n), m_step, m_ir, (m_mode == 0), (m_mode == 2),
                m_ov, m_fault);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microstep_sequencer.md
# microstep_sequencer

Synchronous microcode step sequencer for the TTL CPU simulation. It holds the current instruction byte and a 4-bit microstep count, and presents them together as the microcode ROM address. The "end of instruction" request comes from the quad-OR stage, which ORs the per-instruction terminate lines into one `step_clr` signal. The block also provides an instruction-boundary halt/resume controller and a sticky overrun fault.

## Interface
Parameters:
- `STEP_WIDTH`, 4: microstep counter width.
- `IR_WIDTH`, 8: instruction register width.
- `MAX_STEP`, 15: last legal step. Must be ≤ 2^STEP_WIDTH−1.

Ports:
- `clk`, in, 1: single system clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: clock enable. When low, all state holds.
- `step_clr`, in, 1: end-of-instruction request from the OR stage.
- `ir_load`, in, 1: capture `ir_in` into the IR.
- `ir_in`, in, IR_WIDTH: next instruction byte.
- `halt_req`, in, 1: request halt at the next instruction boundary.
- `resume`, in, 1: leave the halted state.
- `step`, out, STEP_WIDTH: current microstep.
- `ir`, out, IR_WIDTH: current instruction.
- `rom_addr`, out, IR_WIDTH+STEP_WIDTH: `{ir, step}`.
- `fetch`, out, 1: `step == 0`.
- `running`, out, 1: state is RUN.
- `halted`, out, 1: state is HALTED.
- `overrun`, out, 1: one-cycle pulse on wrap past MAX_STEP.
- `fault`, out, 1: sticky overrun flag. Cleared only by `rst`.

## Operation
States:
- RUN: counting.
- HALT_PEND: halt requested, counting continues.
- HALTED: step frozen at 0.

Transitions (evaluated only when `en`=1):
- RUN → HALT_PEND when `halt_req`=1 and no boundary occurs this cycle.
- RUN → HALTED when `halt_req`=1 and a boundary occurs this cycle. The boundary wins; the cycle counts as a boundary.
- HALT_PEND → HALTED at the next boundary.
- HALTED → RUN when `resume`=1. `halt_req` is ignored while HALTED.
- `resume` in RUN or HALT_PEND: ignored.
- A boundary is either `step_clr`=1, or `step==MAX_STEP` (wrap).

Step counter update (when `en`=1, state ≠ HALTED), in priority order:
- `rst`: step ← 0.
- `step_clr`: step ← 0.
- `step == MAX_STEP`: step ← 0, `overrun` pulses, `fault` ← 1.
- Otherwise: step ← step+1, modulo 2^STEP_WIDTH.

Other state rules:
- In HALTED, step holds at 0. A `step_clr` in HALTED has no effect.
- IR: when `en`=1 and `ir_load`=1 and state ≠ HALTED, ir ← `ir_in`. This is independent of the step update. `ir_load` together with `step_clr` in the same cycle does both.
- `fetch` and `rom_addr` are combinational from the registered `step` and `ir`. They add no latency.

## Timing
- Reset values (the edge after `rst`=1): step=0, ir=0, state=RUN, running=1, halted=0, overrun=0, fault=0, fetch=1, rom_addr=0.
- `rst` overrides `en`, including mid-instruction and in HALTED.
- `step_clr` sampled at edge N makes `step` read 0 in cycle N+1. Latency is one edge.
- Increment latency: one edge per `en`-qualified cycle.
- `overrun` is registered. It is high for exactly the cycle after the wrapping edge, then low unless another wrap occurs.
- `ir_load` at edge N: new `ir` and `rom_addr` are visible in cycle N+1.
- `halted` rises in the cycle after the boundary edge. `running` falls in the cycle after `halt_req` is accepted (entry to HALT_PEND or HALTED).
- `resume` at edge N: counting resumes at edge N+1, from step 0.
- `en`=0 freezes everything. Inputs are ignored, and `overrun` is forced to 0.

## Test plan
- Reset then free-run: `rst` 1 cycle, `en`=1, no `step_clr`. Required: step goes 0,1,…,15,0. `overrun` is high one cycle after the 15→0 edge, and `fault` stays 1 afterwards.
- Early terminate: run to step=5, pulse `step_clr`. Required: the next cycle shows step=0, `fetch`=1, no `overrun`, `fault`=0.
- IR load with address: `ir_in`=0xA7 and `ir_load` at step=0. Then step 0→3. Required: `rom_addr` reads 0xA70, 0xA71, 0xA72, 0xA73.
- Halt at boundary: `halt_req` at step=2, then `step_clr` at step=4. Required:
  - step=3 while in HALT_PEND, `running`=0, `halted`=0.
  - After the `step_clr` edge: `halted`=1 and step=0, held for 10 cycles despite `step_clr` and `ir_load` (ir unchanged).
  - `resume`: step=1 one cycle after the edge following resume.
- Simultaneous events: `halt_req`, `step_clr`, and `ir_load` (0x3C) in one cycle at step=7. Required: next cycle has `halted`=1, step=0, ir=0x3C.
- Enable and reset priority: `en`=0 for 4 cycles at step=9 (step holds 9), then `rst`=1 with `en`=0. Required: step=0, ir=0, `fault`=0, state RUN.
